// File: rtl/handshake_receiver_if.sv
// Purpose : upstream valid/ready channel carrying one WIDTH-bit word per transfer.
// Latency : n/a (signal bundle only).
// Backpressure: ready_o, driven by the slave, gates acceptance of valid_i/data_i.
// Ports   : valid_i, data_i (master -> slave); ready_o (slave -> master).
interface handshake_receiver_if #(
  parameter int WIDTH = 8
);
  logic             valid_i;
  logic [WIDTH-1:0] data_i;
  logic             ready_o;

  modport master (
    output valid_i,
    output data_i,
    input  ready_o
  );

  modport slave (
    input  valid_i,
    input  data_i,
    output ready_o
  );
endinterface

// File: rtl/handshake_receiver.sv
// Purpose : sink of a valid/ready channel; buffers accepted words in a FWFT FIFO,
//           counts accepted transfers and flags upstream protocol violations.
// Latency : accept-to-rd_valid_o 1 cycle; pop-while-full to ready_o 1 cycle.
// Backpressure: registered ready_o drops when the next-cycle occupancy reaches DEPTH.
// Ports   : clk, reset (sync, active-low); up (slave modport: valid_i, data_i, ready_o);
//           rd_en_i, rd_valid_o, rd_data_o (consumer read port);
//           count_o (occupancy), rx_total_o (saturating accept count), err_o (sticky).
module handshake_receiver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  handshake_receiver_if.slave        up,
  input  logic                       rd_en_i,
  output logic                       rd_valid_o,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [CNT_W-1:0]           rx_total_o,
  output logic                       err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_ready;
  logic [CNT_W-1:0] r_total;
  logic             r_err;
  // Previous cycle was a stall (valid high, ready low) and the data then offered.
  logic             r_stall;
  logic [WIDTH-1:0] r_prev_data;

  logic             w_push;
  logic             w_pop;
  logic             w_viol;
  logic [AW:0]      w_count_nxt;

  assign w_push = up.valid_i & r_ready;
  // Pop qualified by the registered non-empty flag: a push into an empty
  // FIFO cannot be popped in the same cycle.
  assign w_pop  = rd_en_i & (r_count != '0);
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  // A stalled master must keep valid high and data stable until accepted.
  assign w_viol = r_stall & (~up.valid_i | (up.data_i != r_prev_data));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ready     <= 1'b0;
      r_total     <= '0;
      r_err       <= 1'b0;
      r_stall     <= 1'b0;
      r_prev_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      // Looking at the next occupancy keeps ready_o registered yet never
      // lets a push land on a full FIFO.
      r_ready <= (w_count_nxt < FULL_CNT);
      if (w_push && (r_total != '1)) begin
        r_total <= r_total + CNT_W'(1);
      end
      if (w_viol) begin
        r_err <= 1'b1;
      end
      r_stall     <= up.valid_i & ~r_ready;
      r_prev_data <= up.data_i;
    end
  end

  // Storage needs no reset; the read port masks it while empty.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= up.data_i;
    end
  end

  assign up.ready_o = r_ready;
  assign rd_valid_o = (r_count != '0);
  assign rd_data_o  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count_o    = r_count;
  assign rx_total_o = r_total;
  assign err_o      = r_err;

endmodule
